// File: rtl/rgb_switch_debounce.sv
// Synchronizer and per-bit debouncer for the RGB LED colour switches.
// Produces a debounced colour word plus registered rise/fall/changed strobes.
module rgb_switch_debounce #(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
    logic [WIDTH-1:0][CW-1:0]          cnt_r;
    logic [WIDTH-1:0]                  out_r;
    logic [WIDTH-1:0]                  rise_r;
    logic [WIDTH-1:0]                  fall_r;
    logic                              changed_r;

    logic [WIDTH-1:0]                  sync_s;
    logic [WIDTH-1:0]                  diff_s;
    logic [WIDTH-1:0]                  hit_s;

    assign sync_s  = sync_r[SYNC_STAGES-1];
    assign Out     = out_r;
    assign rise    = rise_r;
    assign fall    = fall_r;
    assign changed = changed_r;

    // Multi-flop synchronizer; stage 0 samples the raw asynchronous lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {(SYNC_STAGES*WIDTH){1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], In};
        end
    end

    // A bit qualifies when it still disagrees with Out at the terminal count.
    always_comb begin
        diff_s = sync_s ^ out_r;
        hit_s  = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (diff_s[i] && (cnt_r[i] == CNT_MAX)) begin
                hit_s[i] = 1'b1;
            end else begin
                hit_s[i] = 1'b0;
            end
        end
    end

    // Per-bit counters, debounced level and edge strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {(WIDTH*CW){1'b0}};
            out_r     <= {WIDTH{1'b0}};
            rise_r    <= {WIDTH{1'b0}};
            fall_r    <= {WIDTH{1'b0}};
            changed_r <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!diff_s[i] || hit_s[i]) begin
                    cnt_r[i] <= {CW{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + CW'(1);
                end
            end
            out_r     <= out_r ^ hit_s;
            rise_r    <= hit_s & sync_s;
            fall_r    <= hit_s & ~sync_s;
            changed_r <= |hit_s;
        end
    end

endmodule

// File: tb/tb_rgb_switch_debounce.sv
// Directed bench for rgb_switch_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_rgb_switch_debounce;

    logic       clk;
    logic       rst;
    logic [5:0] in_s;
    logic [5:0] out_s;
    logic [5:0] rise_s;
    logic [5:0] fall_s;
    logic       changed_s;

    int n_cmp;
    int n_err;

    rgb_switch_debounce #(
        .WIDTH(6),
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .In(in_s),
        .Out(out_s),
        .rise(rise_s),
        .fall(fall_s),
        .changed(changed_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_strobes(input string tag, input logic [5:0] r, input logic [5:0] f, input logic c);
        check_eq({tag, "_rise"}, {26'd0, rise_s}, {26'd0, r});
        check_eq({tag, "_fall"}, {26'd0, fall_s}, {26'd0, f});
        check_eq({tag, "_chg"}, {31'd0, changed_s}, {31'd0, c});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        in_s  = 6'b111111;

        // 1. reset with inputs high, then power-up rise
        step(3);
        check_eq("rst_out", {26'd0, out_s}, 32'd0);
        check_strobes("rst", 6'b000000, 6'b000000, 1'b0);
        rst = 1'b0;
        step(5);
        check_eq("pu_out_e5", {26'd0, out_s}, 32'd0);
        step(1);
        check_eq("pu_out_e6", {26'd0, out_s}, {26'd0, 6'b111111});
        check_strobes("pu_e6", 6'b111111, 6'b000000, 1'b1);
        step(1);
        check_strobes("pu_e7", 6'b000000, 6'b000000, 1'b0);
        check_eq("pu_out_e7", {26'd0, out_s}, {26'd0, 6'b111111});

        // back to zero
        in_s = 6'b000000;
        step(6);
        check_strobes("clr_all", 6'b000000, 6'b111111, 1'b1);
        step(2);

        // 2. clean pattern 000101
        in_s = 6'b000101;
        step(5);
        check_eq("p5_out_e5", {26'd0, out_s}, 32'd0);
        step(1);
        check_eq("p5_out_e6", {26'd0, out_s}, {26'd0, 6'b000101});
        check_strobes("p5_e6", 6'b000101, 6'b000000, 1'b1);
        step(1);
        check_strobes("p5_e7", 6'b000000, 6'b000000, 1'b0);
        in_s = 6'b000000;
        step(5);
        check_eq("p5f_out_e5", {26'd0, out_s}, {26'd0, 6'b000101});
        step(1);
        check_eq("p5f_out_e6", {26'd0, out_s}, 32'd0);
        check_strobes("p5f_e6", 6'b000000, 6'b000101, 1'b1);
        step(2);

        // 3. bounce on bit 2: 1,0,1,1,0 then steady 1
        in_s = 6'b000100; step(1);
        check_eq("bn_out1", {26'd0, out_s}, 32'd0);
        in_s = 6'b000000; step(1);
        check_eq("bn_out2", {26'd0, out_s}, 32'd0);
        in_s = 6'b000100; step(1);
        check_eq("bn_out3", {26'd0, out_s}, 32'd0);
        step(1);
        check_eq("bn_out4", {26'd0, out_s}, 32'd0);
        in_s = 6'b000000; step(1);
        check_eq("bn_out5", {26'd0, out_s}, 32'd0);
        in_s = 6'b000100;
        step(5);
        check_eq("bn_out_e5", {26'd0, out_s}, 32'd0);
        check_strobes("bn_e5", 6'b000000, 6'b000000, 1'b0);
        step(1);
        check_eq("bn_out_e6", {26'd0, out_s}, {26'd0, 6'b000100});
        check_strobes("bn_e6", 6'b000100, 6'b000000, 1'b1);
        in_s = 6'b000000;
        step(8);
        check_eq("bn_clr", {26'd0, out_s}, 32'd0);

        // 4. three-cycle glitch on bit 4 is rejected
        in_s = 6'b010000;
        step(3);
        in_s = 6'b000000;
        for (int k = 0; k < 8; k++) begin
            step(1);
            check_eq("gl_out", {26'd0, out_s}, 32'd0);
            check_eq("gl_chg", {31'd0, changed_s}, 32'd0);
        end
        check_eq("gl_cnt4", {30'd0, dut.cnt_r[4]}, 32'd0);

        // 5. simultaneous rise on bit 5 and fall on bit 0
        in_s = 6'b000001;
        step(8);
        check_eq("sim_pre", {26'd0, out_s}, {26'd0, 6'b000001});
        in_s = 6'b100000;
        step(5);
        check_eq("sim_out_e5", {26'd0, out_s}, {26'd0, 6'b000001});
        step(1);
        check_eq("sim_out_e6", {26'd0, out_s}, {26'd0, 6'b100000});
        check_strobes("sim_e6", 6'b100000, 6'b000001, 1'b1);
        step(1);
        check_strobes("sim_e7", 6'b000000, 6'b000000, 1'b0);

        // 6. asynchronous reset mid-count and mid-cycle
        in_s = 6'b111111;
        step(4);
        check_eq("mc_cnt0", {30'd0, dut.cnt_r[0]}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_out", {26'd0, out_s}, 32'd0);
        check_eq("ar_cnt0", {30'd0, dut.cnt_r[0]}, 32'd0);
        check_strobes("ar", 6'b000000, 6'b000000, 1'b0);
        step(2);
        rst = 1'b0;
        step(5);
        check_eq("ar_out_e5", {26'd0, out_s}, 32'd0);
        step(1);
        check_eq("ar_out_e6", {26'd0, out_s}, {26'd0, 6'b111111});
        check_strobes("ar_e6", 6'b111111, 6'b000000, 1'b1);
        step(1);
        check_strobes("ar_e7", 6'b000000, 6'b000000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rgb_switch_debounce.md
Name: rgb_switch_debounce

Overview:
- Input-side front end for the board's two RGB LEDs. Takes the 6 raw slide-switch/push-button lines, which are asynchronous and bouncy.
- Produces a synchronized, debounced 6-bit colour word that feeds the LED driving logic.
- Also emits per-bit rise/fall strobes and a one-cycle "changed" strobe, so downstream logic can react to colour selections without re-detecting edges.

Parameters:
- WIDTH, 6: number of input lines; the default covers two RGB LEDs of 3 bits each.
- DEBOUNCE_CYCLES, 1000000: consecutive clk cycles a synchronized input must differ from Out before Out follows it (10 ms at 100 MHz). Must be >= 2.
- SYNC_STAGES, 2: depth of the per-bit flip-flop synchronizer. Must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- In  input  WIDTH  raw switch/button levels, asynchronous to clk.
- Out  output  WIDTH  debounced, synchronized level of In.
- rise  output  WIDTH  one-cycle pulse per bit, in the cycle Out[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse per bit, in the cycle Out[i] goes 1->0.
- changed  output  1  one-cycle pulse, equal to OR of (rise | fall).

Behaviour:
- Reset (async assert, all outputs registered):
  - Synchronizer flops, per-bit counters, Out, rise, fall and changed all go to 0 immediately.
  - Deassertion takes effect at the next clk edge.
- Synchronizer: In[i] passes through SYNC_STAGES flops. s[i] is the last stage. No combinational path from In to any output.
- Per-bit debounce, fully independent per bit. Each bit has an unsigned counter cnt[i] of width clog2(DEBOUNCE_CYCLES). On each rising edge:
  - s[i] == Out[i]: cnt[i] <= 0; Out[i] holds.
  - s[i] != Out[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s[i] != Out[i] and cnt[i] == DEBOUNCE_CYCLES-1: Out[i] <= s[i]; cnt[i] <= 0.
  - The counter never wraps. The terminal count always produces an update.
- Latency: In[i] settles before edge E1. Out[i] updates on edge E(SYNC_STAGES+DEBOUNCE_CYCLES), counting E1 as the first edge. Latency is identical for rising and falling transitions.
- Glitch rejection: any excursion with fewer than DEBOUNCE_CYCLES consecutive synchronized cycles in the new state restarts cnt[i] at 0 and leaves Out[i] unchanged. Bounce therefore only extends latency.
- Strobes:
  - rise[i] and fall[i] are registered and assert high for exactly the one cycle following the edge that updated Out[i]; they are coincident with the new Out value.
  - changed is registered, coincident with rise/fall.
  - Strobes are never high for two consecutive cycles on the same bit, because a counter restart needs at least DEBOUNCE_CYCLES cycles.
- Simultaneous events:
  - Bits that qualify on the same edge update together.
  - rise and fall may both be nonzero in the same cycle on different bits; changed is a single pulse.
- Reset mid-count: all counts are discarded and Out returns to 0. An input held at 1 through reset reappears on Out a full SYNC_STAGES+DEBOUNCE_CYCLES edges after release, and produces a rise pulse.
- Power-up with inputs high: this is treated as a normal 0->1 transition, and rise fires.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, WIDTH=6):
1. Reset held, In=6'b111111 -> Out=0, rise=fall=0, changed=0. Release rst with In still 6'b111111 -> Out=6'b111111 on the 6th edge after release; rise=6'b111111 and changed=1 for exactly 1 cycle.
2. From Out=0, set In=6'b000101 cleanly -> Out=6'b000101 on the 6th edge; rise=6'b000101, fall=0, changed=1 for one cycle. Then clear In -> fall=6'b000101 on the 6th edge.
3. Bounce on In[2]: pattern 1,0,1,1,0 (one cycle each), then steady 1 -> no Out change during the bounce. Out[2]=1 on the 6th edge after the last 0->1.
4. 3-cycle glitch In[4]=1 then back to 0 -> Out stays 0, rise/fall/changed never assert, cnt[4] returns to 0.
5. In=6'b100000 and In=6'b000001 changed on the same edge from Out=6'b000001... (i.e. In goes 6'b000001->6'b100000) -> on the 6th edge Out=6'b100000, rise=6'b100000, fall=6'b000001 in the same cycle, changed=1 for one cycle.
6. Assert rst asynchronously mid-count (cnt=2) and mid-cycle -> Out, strobes and counters go to 0 before the next edge. After release, the held input needs a full 6 edges.
